control_unit_param: RTL and testbench

Parametrised one-hot sequencer for the Paul-ALU datapath. It drives add/sub, Radix-4 Booth multiply and SRT-2 divide over a WIDTH-bit datapath. The iteration and leading-zero counters are internal. It adds divide-by-zero trapping, synchronous abort, a busy flag and a registered END pulse. It sits between the bus interface (BEGIN/op_code in, END out) and the register/adder datapath, which decodes `act_state`.

---
 rtl/alu_ctrl_pkg.sv | 31 +++
 rtl/ctrl_counter.sv | 21 ++
 rtl/dff.sv | 12 +
 rtl/dff_rst_to_1.sv | 12 +
 rtl/control_unit_param.sv | 129 ++++++++++++
 tb/tb_control_unit_param.sv | 218 +++++++++++++++++++++
 6 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the Paul-ALU sequencer: one-hot state bit positions and op codes.
package alu_ctrl_pkg;

    localparam int NUM_STATES = 17;

    typedef logic [4:0] st_idx_t;

    localparam st_idx_t S_IDLE           = 5'd0;
    localparam st_idx_t S_LOADA          = 5'd1;
    localparam st_idx_t S_LOADQ          = 5'd2;
    localparam st_idx_t S_LOADM          = 5'd3;
    localparam st_idx_t S_ADDMTOA        = 5'd4;
    localparam st_idx_t S_ADDMTOACORR    = 5'd5;
    localparam st_idx_t S_ADD1TOQPRIM    = 5'd6;
    localparam st_idx_t S_ADDMINQPRIMTOQ = 5'd7;
    localparam st_idx_t S_PUSHA          = 5'd8;
    localparam st_idx_t S_PUSHQ          = 5'd9;
    localparam st_idx_t S_RSHIFT         = 5'd10;
    localparam st_idx_t S_COUNTRSHIFTS   = 5'd11;
    localparam st_idx_t S_LSHIFT         = 5'd12;
    localparam st_idx_t S_COUNTLSHIFTS   = 5'd13;
    localparam st_idx_t S_LSHIFTFOR0     = 5'd14;
    localparam st_idx_t S_RSHIFTFOR0     = 5'd15;
    localparam st_idx_t S_DIV0           = 5'd16;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

endpackage

// File: rtl/ctrl_counter.sv
// Up/down iteration counter with synchronous clear; clear beats inc beats dec.
module ctrl_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clr_i) cnt_q <= '0;
        else if (inc_i)     cnt_q <= cnt_q + W'(1);
        else if (dec_i)     cnt_q <= cnt_q - W'(1);
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/dff.sv
// Single flip-flop cell, synchronous active-high reset to 0.
module dff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk) begin
        if (reset) q <= 1'b0;
        else       q <= d;
    end
endmodule

// File: rtl/dff_rst_to_1.sv
// Single flip-flop cell, synchronous active-high reset to 1 (holds the IDLE bit).
module dff_rst_to_1 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk) begin
        if (reset) q <= 1'b1;
        else       q <= d;
    end
endmodule

// File: rtl/control_unit_param.sv
// One-hot sequencer for add/sub, Radix-4 Booth multiply and SRT-2 divide.
module control_unit_param
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  BEGIN,
    input  logic                  abort,
    input  logic [1:0]            op_code,
    input  logic [2:0]            bits_of_Q,
    input  logic [2:0]            bits_of_A,
    input  logic                  sgn_bit_of_M,
    input  logic                  m_is_zero,
    output logic [NUM_STATES-1:0] act_state,
    output logic                  busy,
    output logic                  END,
    output logic                  err_div0
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [NUM_STATES-1:0] state_q, state_d;
    st_idx_t               nxt, div_tail;
    logic [1:0]            op_q, op_d;
    logic                  srt_flag_q, srt_flag_d;
    logic                  err_q, err_d;
    logic                  end_q, end_d;
    logic [CW-1:0]         r4_cnt, srt_cnt, lz_cnt;
    logic                  booth_nz, a_nz, accept, terminal, cnt_clr;

    assign booth_nz = !(bits_of_Q == 3'b000 || bits_of_Q == 3'b111);
    assign a_nz     = !(bits_of_A == 3'b000 || bits_of_A == 3'b111);
    assign accept   = state_q[S_IDLE] && BEGIN && !abort;
    assign cnt_clr  = abort || state_q[S_LOADM];

    // Exit of an SRT step: last iteration picks the remainder-correction path.
    assign div_tail = (srt_cnt == CW'(WIDTH - 1))
                    ? (bits_of_A[2] ? S_ADDMTOACORR : S_ADDMINQPRIMTOQ)
                    : S_COUNTLSHIFTS;

    always_comb begin
        nxt = S_IDLE;
        case (1'b1)
            state_q[S_IDLE]:        if (BEGIN) nxt = (op_code == OP_MUL) ? S_LOADQ : S_LOADA;
            state_q[S_LOADA]:       nxt = (op_q == OP_DIV) ? S_LOADQ : S_LOADM;
            state_q[S_LOADQ]:       nxt = S_LOADM;
            state_q[S_LOADM]: begin
                if (op_q == OP_MUL)      nxt = booth_nz ? S_ADDMTOA : S_RSHIFT;
                else if (op_q == OP_DIV) nxt = m_is_zero ? S_DIV0
                                             : (sgn_bit_of_M ? S_LSHIFT : S_LSHIFTFOR0);
                else                     nxt = S_ADDMTOA;
            end
            state_q[S_LSHIFTFOR0]:  nxt = sgn_bit_of_M ? S_LSHIFT : S_LSHIFTFOR0;
            state_q[S_LSHIFT]:      nxt = srt_flag_q ? S_ADDMTOA : div_tail;
            state_q[S_ADDMTOA]: begin
                if (op_q == OP_MUL)      nxt = S_RSHIFT;
                else if (op_q == OP_DIV) nxt = div_tail;
                else                     nxt = S_PUSHA;
            end
            state_q[S_COUNTLSHIFTS]:   nxt = S_LSHIFT;
            state_q[S_ADDMTOACORR]:    nxt = S_ADD1TOQPRIM;
            state_q[S_ADD1TOQPRIM]:    nxt = S_ADDMINQPRIMTOQ;
            state_q[S_ADDMINQPRIMTOQ]: nxt = (lz_cnt == '0) ? S_PUSHQ : S_RSHIFTFOR0;
            state_q[S_RSHIFTFOR0]:     nxt = (lz_cnt == CW'(1)) ? S_PUSHQ : S_RSHIFTFOR0;
            state_q[S_RSHIFT]:         nxt = (r4_cnt == CW'(WIDTH / 2 - 1)) ? S_PUSHA : S_COUNTRSHIFTS;
            state_q[S_COUNTRSHIFTS]:   nxt = booth_nz ? S_ADDMTOA : S_RSHIFT;
            state_q[S_PUSHA]:          nxt = (op_q == OP_MUL) ? S_PUSHQ : S_IDLE;
            state_q[S_PUSHQ]:          nxt = (op_q == OP_DIV) ? S_PUSHA : S_IDLE;
            default:                   nxt = S_IDLE;
        endcase
        if (abort) nxt = S_IDLE;
    end

    // Final push depends on operand order: mul ends on PUSHQ, others on PUSHA.
    assign terminal = (state_q[S_PUSHA] && op_q != OP_MUL)
                   || (state_q[S_PUSHQ] && op_q == OP_MUL)
                   ||  state_q[S_DIV0];

    always_comb begin
        state_d    = NUM_STATES'(1) << nxt;
        op_d       = accept ? op_code : op_q;
        srt_flag_d = (nxt == S_LSHIFT) ? a_nz : srt_flag_q;
        end_d      = terminal && !abort;
        err_d      = err_q;
        if (accept)                        err_d = 1'b0;
        else if (state_q[S_DIV0] && !abort) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= OP_ADD;
            srt_flag_q <= 1'b0;
            err_q      <= 1'b0;
            end_q      <= 1'b0;
        end else begin
            op_q       <= op_d;
            srt_flag_q <= srt_flag_d;
            err_q      <= err_d;
            end_q      <= end_d;
        end
    end

    for (genvar i = 0; i < NUM_STATES; i++) begin : g_state
        if (i == int'(S_IDLE)) begin : g_idle
            dff_rst_to_1 u_ff (.clk(clk), .reset(reset), .d(state_d[i]), .q(state_q[i]));
        end else begin : g_other
            dff u_ff (.clk(clk), .reset(reset), .d(state_d[i]), .q(state_q[i]));
        end
    end

    ctrl_counter #(.W(CW)) u_r4_cnt (
        .clk(clk), .reset(reset), .clr_i(cnt_clr),
        .inc_i(state_q[S_COUNTRSHIFTS]), .dec_i(1'b0), .cnt_o(r4_cnt)
    );
    ctrl_counter #(.W(CW)) u_srt_cnt (
        .clk(clk), .reset(reset), .clr_i(cnt_clr),
        .inc_i(state_q[S_COUNTLSHIFTS]), .dec_i(1'b0), .cnt_o(srt_cnt)
    );
    ctrl_counter #(.W(CW)) u_lz_cnt (
        .clk(clk), .reset(reset), .clr_i(cnt_clr),
        .inc_i(state_q[S_LSHIFTFOR0]), .dec_i(state_q[S_RSHIFTFOR0]), .cnt_o(lz_cnt)
    );

    assign act_state = state_q;
    assign busy      = !state_q[S_IDLE];
    assign END       = end_q;
    assign err_div0  = err_q;
endmodule

// File: tb/tb_control_unit_param.sv
// Bench for control_unit_param: directed op sequences plus random traffic against a cycle model.
module tb_control_unit_param;
    localparam int W     = 8;
    localparam int NS    = 17;
    localparam int CMASK = 15;

    typedef enum int {
        M_IDLE, M_LOADA, M_LOADQ, M_LOADM, M_ADDM, M_CORR, M_ADD1, M_ADDMINQ,
        M_PUSHA, M_PUSHQ, M_RSH, M_CNTR, M_LSH, M_CNTL, M_LSH0, M_RSH0, M_DIV0
    } mst_e;

    logic          clk = 1'b0;
    logic          reset, BEGIN, abort, sgn_bit_of_M, m_is_zero;
    logic [1:0]    op_code;
    logic [2:0]    bits_of_Q, bits_of_A;
    logic [NS-1:0] act_state;
    logic          busy, END, err_div0;

    int checks = 0, errors = 0, cyc_n = 0;
    int m_st, m_op, m_r4, m_srt, m_lz;
    bit m_flag, m_err, m_end;
    int vis[NS];
    int end_cyc;
    logic [NS-1:0] tr[0:127];

    control_unit_param #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .BEGIN(BEGIN), .abort(abort), .op_code(op_code),
        .bits_of_Q(bits_of_Q), .bits_of_A(bits_of_A), .sgn_bit_of_M(sgn_bit_of_M),
        .m_is_zero(m_is_zero), .act_state(act_state), .busy(busy), .END(END),
        .err_div0(err_div0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc_n, got, exp);
        end
    endtask

    function automatic int div_tail(input int srt, input bit a2);
        if (srt == W - 1) return a2 ? M_CORR : M_ADDMINQ;
        return M_CNTL;
    endfunction

    // Reference: advance one clock using the sequencing rules directly.
    task automatic model_step();
        bit bnz, anz, fin;
        int nx;
        bnz = !(bits_of_Q == 3'b000 || bits_of_Q == 3'b111);
        anz = !(bits_of_A == 3'b000 || bits_of_A == 3'b111);
        if (reset) begin
            m_st = M_IDLE; m_op = 0; m_r4 = 0; m_srt = 0; m_lz = 0;
            m_flag = 0; m_err = 0; m_end = 0;
            return;
        end
        if (abort) begin
            m_st = M_IDLE; m_r4 = 0; m_srt = 0; m_lz = 0; m_end = 0;
            return;
        end
        fin = 0;
        nx  = M_IDLE;
        case (m_st)
            M_IDLE:    if (BEGIN) begin
                           m_op = int'(op_code); m_err = 0;
                           nx = (m_op == 2) ? M_LOADQ : M_LOADA;
                       end
            M_LOADA:   nx = (m_op == 3) ? M_LOADQ : M_LOADM;
            M_LOADQ:   nx = M_LOADM;
            M_LOADM:   if (m_op < 2) nx = M_ADDM;
                       else if (m_op == 2) nx = bnz ? M_ADDM : M_RSH;
                       else nx = m_is_zero ? M_DIV0 : (sgn_bit_of_M ? M_LSH : M_LSH0);
            M_LSH0:    nx = sgn_bit_of_M ? M_LSH : M_LSH0;
            M_LSH:     nx = m_flag ? M_ADDM : div_tail(m_srt, bits_of_A[2]);
            M_ADDM:    if (m_op < 2) nx = M_PUSHA;
                       else if (m_op == 2) nx = M_RSH;
                       else nx = div_tail(m_srt, bits_of_A[2]);
            M_CNTL:    nx = M_LSH;
            M_CORR:    nx = M_ADD1;
            M_ADD1:    nx = M_ADDMINQ;
            M_ADDMINQ: nx = (m_lz == 0) ? M_PUSHQ : M_RSH0;
            M_RSH0:    nx = (m_lz == 1) ? M_PUSHQ : M_RSH0;
            M_RSH:     nx = (m_r4 == W / 2 - 1) ? M_PUSHA : M_CNTR;
            M_CNTR:    nx = bnz ? M_ADDM : M_RSH;
            M_PUSHA:   if (m_op == 2) nx = M_PUSHQ; else fin = 1;
            M_PUSHQ:   if (m_op == 3) nx = M_PUSHA; else fin = 1;
            M_DIV0:    begin m_err = 1; fin = 1; end
            default:   nx = M_IDLE;
        endcase
        case (m_st)
            M_LOADM: begin m_r4 = 0; m_srt = 0; m_lz = 0; end
            M_CNTR:  m_r4++;
            M_CNTL:  m_srt++;
            M_LSH0:  m_lz = (m_lz + 1) & CMASK;
            M_RSH0:  m_lz = (m_lz - 1) & CMASK;
            default: ;
        endcase
        if (nx == M_LSH) m_flag = anz;
        m_end = fin;
        m_st  = nx;
    endtask

    task automatic check_model();
        logic [NS-1:0] es;
        es = '0;
        es[m_st] = 1'b1;
        chk("act_state", act_state, es);
        chk("onehot", $countones(act_state), 1);
        chk("busy", busy, (m_st != M_IDLE));
        chk("END", END, m_end);
        chk("err_div0", err_div0, m_err);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc_n++;
        check_model();
    endtask

    // BEGIN in cycle 0; sgn_bit_of_M low in cycles lo..hi; abort in cycle ab.
    task automatic run_op(input logic [1:0] op, input int lo, input int hi,
                          input int ab, input int ncyc);
        for (int i = 0; i < NS; i++) vis[i] = 0;
        end_cyc = -1;
        op_code = op; BEGIN = 1'b1; sgn_bit_of_M = 1'b1; abort = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            cyc();
            BEGIN = 1'b0;
            tr[c] = act_state;
            for (int i = 0; i < NS; i++) if (act_state[i]) vis[i]++;
            sgn_bit_of_M = !(c >= lo && c <= hi);
            abort = (c == ab);
            if (END) begin end_cyc = c; break; end
        end
        abort = 1'b0;
    endtask

    initial begin
        reset = 1'b1; BEGIN = 1'b0; abort = 1'b0; op_code = 2'b00;
        bits_of_Q = 3'b000; bits_of_A = 3'b000; sgn_bit_of_M = 1'b1; m_is_zero = 1'b0;
        cyc(); cyc();
        chk("rst_state", act_state, 1);
        chk("rst_busy", busy, 0);
        chk("rst_end", END, 0);
        chk("rst_err", err_div0, 0);
        reset = 1'b0;
        cyc();

        run_op(2'b00, -1, -1, -1, 40);
        chk("add_c1", tr[1], 17'h2);
        chk("add_c2", tr[2], 17'h8);
        chk("add_c3", tr[3], 17'h10);
        chk("add_c4", tr[4], 17'h100);
        chk("add_end", end_cyc, 5);

        run_op(2'b10, -1, -1, -1, 40);
        chk("mul_c3", tr[3], 17'h400);
        chk("mul_c5", tr[5], 17'h400);
        chk("mul_c9", tr[9], 17'h400);
        chk("mul_c10", tr[10], 17'h100);
        chk("mul_c11", tr[11], 17'h200);
        chk("mul_end", end_cyc, 12);
        chk("mul_no_addm", vis[M_ADDM], 0);

        m_is_zero = 1'b1;
        run_op(2'b11, -1, -1, -1, 40);
        chk("div0_c4", tr[4], 17'h10000);
        chk("div0_end", end_cyc, 5);
        chk("div0_err", err_div0, 1);
        m_is_zero = 1'b0;
        run_op(2'b01, -1, -1, -1, 40);
        chk("div0_err_clr", err_div0, 0);
        chk("sub_end", end_cyc, 5);

        run_op(2'b11, -1, -1, -1, 80);
        chk("div_lsh", vis[M_LSH], 8);
        chk("div_cntl", vis[M_CNTL], 7);
        chk("div_addminq", vis[M_ADDMINQ], 1);
        chk("div_end", end_cyc, 22);

        run_op(2'b11, 3, 5, -1, 80);
        chk("lz_lsh0", vis[M_LSH0], 3);
        chk("lz_rsh0", vis[M_RSH0], 3);
        chk("lz_end", end_cyc, 28);

        bits_of_A = 3'b111;
        run_op(2'b11, -1, -1, -1, 80);
        chk("corr_visit", vis[M_CORR], 1);
        chk("corr_add1", vis[M_ADD1], 1);
        chk("corr_end", end_cyc, 24);
        bits_of_A = 3'b000;

        run_op(2'b10, -1, -1, 6, 7);
        chk("abort_idle", tr[7], 17'h1);
        chk("abort_no_end", end_cyc, -1);
        run_op(2'b10, -1, -1, -1, 40);
        chk("post_abort_end", end_cyc, 12);

        for (int k = 0; k < 3000; k++) begin
            reset        = ($urandom_range(0, 499) == 0);
            abort        = ($urandom_range(0, 39) == 0);
            BEGIN        = ($urandom_range(0, 2) == 0);
            op_code      = 2'($urandom_range(0, 3));
            bits_of_Q    = 3'($urandom_range(0, 7));
            bits_of_A    = 3'($urandom_range(0, 7));
            sgn_bit_of_M = ($urandom_range(0, 3) != 0);
            m_is_zero    = ($urandom_range(0, 7) == 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
